wb_daq_data_packer: RTL
=======================

// Module: wb_daq_data_packer
// PURPOSE
//  Multi-channel successor to the DAQ aggregation stage. Packs adc_dw-bit ADC samples, tagged by channel,
//  into dw-bit words for the sample FIFO, with independent per-channel packing.
//  Adds an unpacked sign/zero-extend mode, a flush of partial words, FIFO backpressure and overflow reporting.
//  Sits between the ADC capture logic and the WB DAQ FIFO.
// PARAMETERS
//  dw      32  output word width
//  adc_dw  8   sample width; legal values 8, 16, 32; dw % adc_dw == 0
//  num_ch  2   channel count, 1..8; ch_w = (num_ch>1) ? $clog2(num_ch) : 1 (localparam)
// PORTS
//  wb_clk       in   1       clock
//  wb_rst_n     in   1       reset; asynchronous, active-low
//  enable       in   1       0: data_ready ignored; packing state held
//  pack_mode    in   1       1: pack dw/adc_dw samples per word; 0: one extended sample per word
//  signed_data  in   1       unpacked mode only: 1 sign-extend, 0 zero-extend
//  data_ready   in   1       sample strobe
//  adc_data_in  in   adc_dw  sample
//  adc_ch       in   ch_w    sample channel; values >= num_ch dropped, set overflow
//  flush        in   1       pulse: emit all partial words
//  fifo_full    in   1       FIFO backpressure
//  clr_overflow in   1       clears overflow
//  data_out     out  dw      word presented to FIFO
//  data_ch      out  ch_w    channel of data_out
//  fifo_push    out  1       = out_valid & ~fifo_full (combinational); word retires this cycle
//  flush_busy   out  1       flush in progress
//  overflow     out  1       sticky: a sample or word was dropped
// BEHAVIOUR
//  Reset: data_out=0, data_ch=0, out_valid=0, flush_busy=0, overflow=0, all lane counters/staging=0.
//  Per channel: staging register (dw) + lane counter (0..dw/adc_dw-1).
//   Sample k goes to bits [k*adc_dw +: adc_dw]; lane 0 = LSBs.
//  Accepted sample (data_ready & enable & ~flush_busy & adc_ch<num_ch) writes the lane and increments the counter.
//   A sample in the last lane completes the word; the counter wraps to 0.
//  Unpacked mode: every sample completes a word: {ext,sample}. adc_dw==dw => both modes identical.
//  Completed word loads the output register next cycle if out_valid==0 or fifo_push==1 this cycle.
//   Latency: completing sample at cycle N -> data_out/fifo_push at N+1 (if ~fifo_full).
//  Output register occupied and not retiring => completed word dropped, overflow<=1; channel staging clears.
//  fifo_full held => data_out/data_ch stable; fifo_push low.
//  pack_mode change (registered compare): all lane counters/staging clear next cycle; partial data discarded.
//  FSM (encodings in shared include):
//   IDLE -> FLUSH on flush; channel index=0, flush_busy=1.
//   FLUSH: scan one channel per cycle, ascending.
//    Counter>0 and output register free: load staging (unused lanes 0), clear counter, advance.
//    Counter>0 and output register busy: stall on that channel.
//    Counter==0: skip.
//    After channel num_ch-1 -> IDLE; flush_busy=0.
//   flush while FLUSH: ignored.
//  Simultaneous events:
//   data_ready+flush same cycle: sample accepted first, then included in flush.
//   data_ready during FLUSH: dropped, overflow<=1.
//   Word load + retire same cycle: no overflow.
//   clr_overflow + new drop same cycle: overflow stays 1 (set wins).
//  Async reset mid-word/mid-flush: all state to reset values immediately; no stale lanes after release.
// STRUCTURE
//  Shared include wb_daq_defines.vh: FSM state encodings (IDLE, FLUSH); legal adc_dw values; ch_w function.
//  Sub-module wb_daq_lane_packer: one per channel (generate).
//   Owns staging, lane counter, extension, word_done/partial outputs.
//  Top: channel decode, output register, flush FSM, overflow.
// TESTING (dw=32, adc_dw=8, num_ch=2 unless stated)
//  ch0 samples 11,22,33,44 -> one fifo_push, data_out=32'h44332211, data_ch=0, cycle after 4th sample.
//  Interleave ch0 01,ch1 A1,ch0 02,ch1 A2 x2 -> 32'h02010201 ch0, then 32'hA2A1A2A1 ch1; no mixing.
//  pack_mode=0: 8'h80 with signed_data=1 -> 32'hFFFFFF80; with signed_data=0 -> 32'h00000080.
//  ch0 AA,BB; ch1 CC; flush -> 32'h0000BBAA ch0, then 32'h000000CC ch1; flush_busy then drops; counters 0.
//  fifo_full=1, complete two ch0 words -> first held on data_out, second dropped, overflow=1.
//   Release full -> one push; clr_overflow -> 0.
//  Assert wb_rst_n low after two ch0 samples -> outputs 0 at once.
//   After release, 4 samples -> exactly those bytes, no stale lanes.

Source files
------------

// File: rtl/wb_daq_data_packer_pkg.sv
// Shared types and helpers for the DAQ data packer.
// Flush FSM states, channel-width and sample-width helpers.
package wb_daq_data_packer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit legal_adc_dw(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/wb_daq_data_packer_if.sv
// Sample-in / word-out bus of the DAQ data packer.
// master drives samples and backpressure; slave is the packer.
interface wb_daq_data_packer_if #(
  parameter int dw     = 32,
  parameter int adc_dw = 8,
  parameter int ch_w   = 1
);
  logic              data_ready;
  logic [adc_dw-1:0] adc_data_in;
  logic [ch_w-1:0]   adc_ch;
  logic              fifo_full;
  logic [dw-1:0]     data_out;
  logic [ch_w-1:0]   data_ch;
  logic              fifo_push;

  modport master (
    output data_ready, adc_data_in, adc_ch, fifo_full,
    input  data_out, data_ch, fifo_push
  );

  modport slave (
    input  data_ready, adc_data_in, adc_ch, fifo_full,
    output data_out, data_ch, fifo_push
  );
endinterface

// File: rtl/wb_daq_lane_packer.sv
// Per-channel staging register and lane counter.
// Flags a completed word combinationally with its contents.
module wb_daq_lane_packer #(
  parameter int dw     = 32,
  parameter int adc_dw = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              pack_mode,
  input  logic              signed_data,
  input  logic              we,
  input  logic [adc_dw-1:0] sample,
  input  logic              clr,
  output logic              word_done,
  output logic [dw-1:0]     word,
  output logic [dw-1:0]     stage,
  output logic              partial
);

  localparam int lanes = dw / adc_dw;
  localparam int cnt_w = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [cnt_w-1:0] last = cnt_w'(lanes - 1);

  logic [dw-1:0]    staging;
  logic [cnt_w-1:0] cnt;
  logic [dw-1:0]    written;
  logic [dw-1:0]    ext;

  // Build packed and extended candidate words for this sample
  always_comb begin
    written = staging;
    written[int'(cnt)*adc_dw +: adc_dw] = sample;
    ext = '0;
    ext[adc_dw-1:0] = sample;
    for (int i = adc_dw; i < dw; i++)
      ext[i] = signed_data & sample[adc_dw-1];
    word_done = we & (~pack_mode | (cnt == last));
    word      = pack_mode ? written : ext;
  end

  assign stage   = staging;
  assign partial = (cnt != '0);

  // Staging and lane counter; a completed word leaves the lane empty
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      staging <= '0;
      cnt     <= '0;
    end else if (clr || word_done) begin
      staging <= '0;
      cnt     <= '0;
    end else if (we) begin
      staging <= written;
      cnt     <= cnt + cnt_w'(1);
    end
  end

endmodule

// File: rtl/wb_daq_data_packer.sv
// Multi-channel ADC sample packer feeding the WB DAQ FIFO.
// Channel decode, output register, flush FSM and overflow flag.
module wb_daq_data_packer
  import wb_daq_data_packer_pkg::*;
#(
  parameter int dw     = 32,
  parameter int adc_dw = 8,
  parameter int num_ch = 2
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic enable,
  input  logic pack_mode,
  input  logic signed_data,
  input  logic flush,
  input  logic clr_overflow,
  wb_daq_data_packer_if.slave bus,
  output logic flush_busy,
  output logic overflow
);

  localparam int ch_w = ch_width(num_ch);
  localparam logic [ch_w-1:0] last_ch = ch_w'(num_ch - 1);

  state_t state_q, state_d;
  logic [ch_w-1:0] fl_ch_q;
  logic            pack_mode_q;
  logic            mode_clr;

  logic [num_ch-1:0] lane_we, lane_done, lane_part, lane_take;
  logic [dw-1:0]     lane_word  [num_ch];
  logic [dw-1:0]     lane_stage [num_ch];

  logic            out_valid;
  logic [dw-1:0]   out_word;
  logic [ch_w-1:0] out_ch;
  logic            push, free, accept, ch_hit, drop;
  logic            done_any;
  logic [dw-1:0]   done_word;
  logic [ch_w-1:0] done_ch;
  logic            fl_part, fl_go, fl_stall;
  logic [dw-1:0]   fl_word;

  assign mode_clr = pack_mode ^ pack_mode_q;
  assign push     = out_valid & ~bus.fifo_full;
  assign free     = ~out_valid | push;

  assign bus.data_out  = out_word;
  assign bus.data_ch   = out_ch;
  assign bus.fifo_push = push;

  // Route the sample to its channel lane and pick completed/flush words
  always_comb begin
    accept    = bus.data_ready & enable & ~flush_busy;
    ch_hit    = 1'b0;
    lane_we   = '0;
    done_word = '0;
    done_ch   = '0;
    fl_part   = 1'b0;
    fl_word   = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (bus.adc_ch == ch_w'(i)) begin
        ch_hit     = 1'b1;
        lane_we[i] = accept & ~mode_clr;
      end
      if (lane_done[i]) begin
        done_word = lane_word[i];
        done_ch   = ch_w'(i);
      end
      if (fl_ch_q == ch_w'(i)) begin
        fl_part = lane_part[i];
        fl_word = lane_stage[i];
      end
    end
    done_any = |lane_done;
    drop = (done_any & ~free)
         | (bus.data_ready & enable & flush_busy)
         | (accept & ~ch_hit);
  end

  for (genvar g = 0; g < num_ch; g++) begin : g_lane
    wb_daq_lane_packer #(
      .dw     (dw),
      .adc_dw (adc_dw)
    ) u_lane (
      .wb_clk      (wb_clk),
      .wb_rst_n    (wb_rst_n),
      .pack_mode   (pack_mode),
      .signed_data (signed_data),
      .we          (lane_we[g]),
      .sample      (bus.adc_data_in),
      .clr         (mode_clr | lane_take[g]),
      .word_done   (lane_done[g]),
      .word        (lane_word[g]),
      .stage       (lane_stage[g]),
      .partial     (lane_part[g])
    );
  end

  // Flush FSM state register
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Flush FSM next state: scan ends after the last channel
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (!fl_stall && fl_ch_q == last_ch) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush FSM outputs: take a partial word when the output register is free
  always_comb begin
    flush_busy = (state_q == ST_FLUSH);
    fl_go      = flush_busy & fl_part & free;
    fl_stall   = flush_busy & fl_part & ~free;
    lane_take  = '0;
    for (int i = 0; i < num_ch; i++)
      lane_take[i] = fl_go & (fl_ch_q == ch_w'(i));
  end

  // Flush scan index, one channel per cycle unless stalled
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      fl_ch_q <= '0;
    end else if (flush_busy && !fl_stall) begin
      fl_ch_q <= (fl_ch_q == last_ch) ? '0 : fl_ch_q + ch_w'(1);
    end
  end

  // Output register: load a new word or retire the current one
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_ch    <= '0;
    end else if (fl_go) begin
      out_valid <= 1'b1;
      out_word  <= fl_word;
      out_ch    <= fl_ch_q;
    end else if (done_any && free) begin
      out_valid <= 1'b1;
      out_word  <= done_word;
      out_ch    <= done_ch;
    end else if (push) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow and registered pack_mode for change detection
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      overflow    <= 1'b0;
      pack_mode_q <= 1'b0;
    end else begin
      pack_mode_q <= pack_mode;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
